// File: rtl/sd_io_pkg.sv
// Shared constants and types for the SD-card SPI-master IO peripheral.
package sd_io_pkg;

  localparam logic [7:0] ADDR_STATUS = 8'hA0;
  localparam logic [7:0] ADDR_DATA   = 8'hA2;
  localparam logic [7:0] ADDR_CTRL   = 8'hA4;
  localparam logic [7:0] ADDR_CLKDIV = 8'hA6;

  localparam logic [4:0] IO_PAGE    = ADDR_STATUS[7:3];
  localparam logic [1:0] REG_STATUS = ADDR_STATUS[2:1];
  localparam logic [1:0] REG_DATA   = ADDR_DATA[2:1];
  localparam logic [1:0] REG_CTRL   = ADDR_CTRL[2:1];
  localparam logic [1:0] REG_CLKDIV = ADDR_CLKDIV[2:1];

  localparam int unsigned ST_BUSY     = 0;
  localparam int unsigned ST_RX_VALID = 1;
  localparam int unsigned ST_TX_FULL  = 2;
  localparam int unsigned ST_OVERRUN  = 3;
  localparam int unsigned CTRL_CS     = 0;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam logic [7:0] CLKDIV_RST = 8'hFF;

  typedef enum logic {SPI_IDLE, SPI_SHIFT} spi_state_e;

endpackage

// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte shifter, MSB first; SCLK toggles every div+1 clocks.
module sd_spi_byte
  import sd_io_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] div,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       busy,
  output logic       done_c,
  output logic [7:0] rx_byte,
  output logic       sclk,
  output logic       mosi
);

  spi_state_e state;
  logic [7:0] div_q;
  logic [7:0] cnt;
  logic [3:0] half;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic       sclk_q;

  assign busy    = (state == SPI_SHIFT);
  assign sclk    = sclk_q;
  assign mosi    = tx_sh[7];
  assign rx_byte = rx_sh;
  // Last half-period expiring: SCLK is about to fall for the 8th time.
  assign done_c  = (state == SPI_SHIFT) && (cnt == 8'd0) && (half == 4'd15) && sclk_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= SPI_IDLE;
      div_q  <= 8'd0;
      cnt    <= 8'd0;
      half   <= 4'd0;
      tx_sh  <= 8'hFF;
      rx_sh  <= 8'd0;
      sclk_q <= 1'b0;
    end else begin
      case (state)
        SPI_IDLE: begin
          if (start) begin
            state  <= SPI_SHIFT;
            div_q  <= div;
            cnt    <= div;
            half   <= 4'd0;
            tx_sh  <= tx_byte;
            sclk_q <= 1'b0;
          end
        end
        SPI_SHIFT: begin
          if (cnt == 8'd0) begin
            cnt    <= div_q;
            half   <= 4'(half + 4'd1);
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              rx_sh <= {rx_sh[6:0], miso};
            end else if (half == 4'd15) begin
              state <= SPI_IDLE;
              tx_sh <= 8'hFF;
            end else begin
              tx_sh <= {tx_sh[6:0], 1'b1};
            end
          end else begin
            cnt <= 8'(cnt - 8'd1);
          end
        end
        default: state <= SPI_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sd_io_wrap.sv
// IO-bus register front end for the SD SPI master (regs at 0xA0-0xA7).
// Optional interrupt output and CTRL.irq_en enabled by SD_IO_WRAP_IRQ_EN.
module sd_io_wrap
  import sd_io_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_IO_addr,
  input  logic [15:0] i_IO_data,
  input  logic        i_IO_we,
  input  logic        i_IO_re,
  output logic [15:0] o_IO_data,
  output logic        o_sd_sclk,
  output logic        o_sd_mosi,
  input  logic        i_sd_miso,
  output logic        o_sd_cs_n
`ifdef SD_IO_WRAP_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  logic       hit, wr_status, wr_data, wr_ctrl, wr_div, rd_data;
  logic       busy_any, buf_wr, drop, start_c;
  logic [1:0] rsel;
  logic [7:0] start_byte;
  logic       eng_busy, eng_done_c;
  logic [7:0] eng_rx;

  logic       rx_valid, tx_full, overrun, restart_q;
  logic [7:0] rx_q, tx_buf, div_q;
  logic       irq_en;
  logic       unused;

  assign unused = &{1'b0, i_IO_data[15:8], i_IO_addr[0]};

  // Decode and transfer-launch decisions.
  always_comb begin
    hit        = (i_IO_addr[7:3] == IO_PAGE);
    rsel       = i_IO_addr[2:1];
    wr_status  = hit && i_IO_we && (rsel == REG_STATUS);
    wr_data    = hit && i_IO_we && (rsel == REG_DATA);
    wr_ctrl    = hit && i_IO_we && (rsel == REG_CTRL);
    wr_div     = hit && i_IO_we && (rsel == REG_CLKDIV);
    rd_data    = hit && (i_IO_re === 1'b1) && (rsel == REG_DATA);
    busy_any   = eng_busy | restart_q;
    buf_wr     = wr_data & busy_any & ~tx_full;
    drop       = wr_data & busy_any & tx_full;
    start_c    = restart_q | (wr_data & ~busy_any);
    start_byte = restart_q ? tx_buf : i_IO_data[7:0];
  end

  // Readback mux, zero latency.
  always_comb begin
    o_IO_data = 16'd0;
    if (hit) begin
      case (rsel)
        REG_STATUS: begin
          o_IO_data[ST_BUSY]     = busy_any;
          o_IO_data[ST_RX_VALID] = rx_valid;
          o_IO_data[ST_TX_FULL]  = tx_full;
          o_IO_data[ST_OVERRUN]  = overrun;
        end
        REG_DATA: o_IO_data[7:0] = rx_q;
        REG_CTRL: begin
          o_IO_data[CTRL_CS]     = ~o_sd_cs_n;
          o_IO_data[CTRL_IRQ_EN] = irq_en;
        end
        default: o_IO_data[7:0] = div_q;
      endcase
    end
  end

  sd_spi_byte u_spi (
    .clk     (clk),
    .reset   (reset),
    .start   (start_c),
    .div     (div_q),
    .tx_byte (start_byte),
    .miso    (i_sd_miso),
    .busy    (eng_busy),
    .done_c  (eng_done_c),
    .rx_byte (eng_rx),
    .sclk    (o_sd_sclk),
    .mosi    (o_sd_mosi)
  );

  // A buffered byte (already held, or written on the completing edge) restarts one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_valid  <= 1'b0;
      tx_full   <= 1'b0;
      overrun   <= 1'b0;
      restart_q <= 1'b0;
      rx_q      <= 8'd0;
      tx_buf    <= 8'd0;
      div_q     <= CLKDIV_RST;
      o_sd_cs_n <= 1'b1;
    end else begin
      if (eng_done_c) begin
        rx_q      <= eng_rx;
        rx_valid  <= 1'b1;
        restart_q <= tx_full | buf_wr;
        tx_full   <= 1'b0;
      end else begin
        restart_q <= 1'b0;
        if (buf_wr)  tx_full  <= 1'b1;
        if (rd_data) rx_valid <= 1'b0;
      end
      if (buf_wr) tx_buf <= i_IO_data[7:0];
      if (drop || (eng_done_c && rx_valid)) overrun <= 1'b1;
      else if (wr_status && i_IO_data[ST_OVERRUN]) overrun <= 1'b0;
      if (wr_ctrl) o_sd_cs_n <= ~i_IO_data[CTRL_CS];
      if (wr_div)  div_q     <= i_IO_data[7:0];
    end
  end

`ifdef SD_IO_WRAP_IRQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en <= 1'b0;
      o_irq  <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= i_IO_data[CTRL_IRQ_EN];
      o_irq <= irq_en & rx_valid;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_sd_io_wrap.sv
// Randomized self-checking bench for sd_io_wrap with an SPI-slave view of the pins.
module tb_sd_io_wrap;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [15:0] rdata;
  logic        sclk, mosi, miso, cs_n;
`ifdef SD_IO_WRAP_IRQ_EN
  logic        irq;
`endif

  int          n_tests = 0;
  int          n_fail = 0;

  // SPI-slave model state
  logic        loop_mode = 1'b0;
  logic [7:0]  pat_byte = 8'h00;
  int          edges = 0;
  int          base = 0;
  logic [7:0]  cap = 8'h00;
  time         last_rise = 0;
  time         prev_rise = 0;
  logic        pat_bit;

  sd_io_wrap dut (
    .clk       (clk),
    .reset     (reset),
    .i_IO_addr (addr),
    .i_IO_data (wdata),
    .i_IO_we   (we),
    .i_IO_re   (re),
    .o_IO_data (rdata),
    .o_sd_sclk (sclk),
    .o_sd_mosi (mosi),
    .i_sd_miso (miso),
    .o_sd_cs_n (cs_n)
`ifdef SD_IO_WRAP_IRQ_EN
    ,
    .o_irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    cap       = {cap[6:0], mosi};
    edges     = edges + 1;
    prev_rise = last_rise;
    last_rise = $time;
  end

  always_comb begin
    int k;
    k = edges - base;
    pat_bit = (k >= 0 && k < 8) ? pat_byte[3'(7 - k)] : 1'b0;
  end

  assign miso = loop_mode ? mosi : pat_bit;

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, output logic [15:0] d);
    addr = a; #1;
    d = rdata;
  endtask

  task automatic rd_clr(input logic [7:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    addr = a; re = 1'b1; #1;
    d = rdata;
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic wait_low(input int b, output int cycles);
    logic [15:0] s;
    cycles = 0;
    peek(8'hA0, s);
    while (s[b] && cycles < 5000) begin
      @(posedge clk); #2;
      s = rdata;
      cycles++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n got %b exp 1", cs_n); end
    n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL rst_sclk got %b exp 0", sclk); end
    n_tests++; if (mosi !== 1'b1) begin n_fail++; $display("FAIL rst_mosi got %b exp 1", mosi); end
    reset = 1'b1;
    @(posedge clk); #1;
    peek(8'hA0, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_status got %h exp 0000", d); end
    peek(8'hA6, d);
    n_tests++; if (d !== 16'h00FF) begin n_fail++; $display("FAIL rst_clkdiv got %h exp 00ff", d); end
    peek(8'hA2, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_data got %h exp 0000", d); end
    peek(8'hA4, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_ctrl got %h exp 0000", d); end
  endtask

  task automatic test_basic();
    logic [15:0] d;
    int c;
    loop_mode = 1'b0; pat_byte = 8'h00;
    wr(8'hA6, 16'd9);
    base = edges;
    wr(8'hA2, 16'h00FF);
    peek(8'hA0, d);
    n_tests++; if (d[0] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start got %b exp 1", d[0]); end
    wait_low(0, c);
    n_tests++; if (c != 160) begin n_fail++; $display("FAIL basic_busy_cycles got %0d exp 160", c); end
    n_tests++; if (edges - base != 8) begin n_fail++; $display("FAIL basic_sclk_pulses got %0d exp 8", edges - base); end
    n_tests++; if (last_rise - prev_rise != 200) begin n_fail++; $display("FAIL basic_sclk_period got %0t exp 200", last_rise - prev_rise); end
    n_tests++; if (cap !== 8'hFF) begin n_fail++; $display("FAIL basic_mosi got %h exp ff", cap); end
    n_tests++; if (sclk !== 1'b0 || mosi !== 1'b1) begin n_fail++; $display("FAIL basic_idle_pins got %b%b exp 01", sclk, mosi); end
    peek(8'hA0, d);
    n_tests++; if (d !== 16'h0002) begin n_fail++; $display("FAIL basic_status got %h exp 0002", d); end
    peek(8'hA2, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL basic_data got %h exp 0000", d); end
  endtask

  task automatic test_buffered();
    logic [15:0] d;
    logic [7:0]  b1;
    int c;
    b1 = 8'($urandom);
    loop_mode = 1'b0; pat_byte = 8'($urandom);
    wr(8'hA6, 16'd9);
    base = edges;
    wr(8'hA2, {8'h00, b1});
    repeat (30) @(posedge clk);
    wr(8'hA6, 16'd0);
    wr(8'hA2, 16'h0040);
    peek(8'hA0, d);
    n_tests++; if (d !== 16'h0007 && d !== 16'h0005) begin n_fail++; $display("FAIL buf_status got %h exp busy+tx_full", d); end
    n_tests++; if (d[2] !== 1'b1) begin n_fail++; $display("FAIL buf_tx_full got %b exp 1", d[2]); end
    wait_low(2, c);
    n_tests++; if (cap !== b1) begin n_fail++; $display("FAIL buf_first_mosi got %h exp %h", cap, b1); end
    pat_byte = 8'h00;
    base = edges;
    wait_low(0, c);
    n_tests++; if (c != 17) begin n_fail++; $display("FAIL buf_second_cycles got %0d exp 17", c); end
    n_tests++; if (cap !== 8'h40) begin n_fail++; $display("FAIL buf_second_mosi got %h exp 40", cap); end
    peek(8'hA0, d);
    n_tests++; if (d !== 16'h000A) begin n_fail++; $display("FAIL buf_end_status got %h exp 000a", d); end
    wr(8'hA0, 16'h0008);
    rd_clr(8'hA2, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL buf_data got %h exp 0000", d); end
    peek(8'hA0, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL buf_cleared got %h exp 0000", d); end
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [7:0]  tx, exp_rx, dv;
    int c;
    for (int i = 0; i < 8; i++) begin
      dv        = (i == 0) ? 8'd1 : 8'($urandom_range(0, 3));
      tx        = (i == 0) ? 8'hA5 : 8'($urandom);
      loop_mode = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      pat_byte  = 8'($urandom);
      exp_rx    = loop_mode ? tx : pat_byte;
      wr(8'hA6, {8'h00, dv});
      base = edges;
      wr(8'hA2, {8'h00, tx});
      wait_low(0, c);
      n_tests++; if (c != 16 * (int'(dv) + 1)) begin n_fail++; $display("FAIL rnd%0d_cycles got %0d exp %0d", i, c, 16 * (int'(dv) + 1)); end
      n_tests++; if (cap !== tx) begin n_fail++; $display("FAIL rnd%0d_mosi got %h exp %h", i, cap, tx); end
      peek(8'hA0, d);
      n_tests++; if (d !== 16'h0002) begin n_fail++; $display("FAIL rnd%0d_status got %h exp 0002", i, d); end
      rd_clr(8'hA2, d);
      n_tests++; if (d !== {8'h00, exp_rx}) begin n_fail++; $display("FAIL rnd%0d_rx got %h exp %h", i, d, exp_rx); end
      peek(8'hA0, d);
      n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rnd%0d_rxv_clear got %h exp 0000", i, d); end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] d;
    logic [7:0]  b2;
    int c;
    b2 = 8'($urandom);
    loop_mode = 1'b1;
    wr(8'hA6, 16'd3);
    wr(8'hA2, 16'h0011);
    wr(8'hA2, {8'h00, b2});
    wr(8'hA2, 16'h0033);
    peek(8'hA0, d);
    n_tests++; if (d !== 16'h000D) begin n_fail++; $display("FAIL ovr_status got %h exp 000d", d); end
    wait_low(0, c);
    n_tests++; if (c > 200) begin n_fail++; $display("FAIL ovr_idle_timeout got %0d exp <=200", c); end
    peek(8'hA0, d);
    n_tests++; if (d !== 16'h000A) begin n_fail++; $display("FAIL ovr_end_status got %h exp 000a", d); end
    peek(8'hA2, d);
    n_tests++; if (d !== {8'h00, b2}) begin n_fail++; $display("FAIL ovr_last_rx got %h exp %h", d, b2); end
    wr(8'hA0, 16'h0008);
    peek(8'hA0, d);
    n_tests++; if (d !== 16'h0002) begin n_fail++; $display("FAIL ovr_clear got %h exp 0002", d); end
    rd_clr(8'hA2, d);
    peek(8'hA0, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL ovr_all_clear got %h exp 0000", d); end
  endtask

  task automatic test_ctrl_miss();
    logic [15:0] d;
    wr(8'hA4, 16'h0003);
    n_tests++; if (cs_n !== 1'b0) begin n_fail++; $display("FAIL ctrl_cs_n got %b exp 0", cs_n); end
    peek(8'hA4, d);
    n_tests++; if (d[0] !== 1'b1 || d[15:3] !== 13'd0 || d[1] !== 1'b0) begin n_fail++; $display("FAIL ctrl_read got %h exp cs=1", d); end
    wr(8'hA6, 16'hABCD);
    peek(8'hA7, d);
    n_tests++; if (d !== 16'h00CD) begin n_fail++; $display("FAIL clkdiv_read got %h exp 00cd", d); end
    wr(8'hB0, 16'hFFFF);
    wr(8'hB6, 16'hFFFF);
    peek(8'hB0, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL miss_read got %h exp 0000", d); end
    peek(8'hA0, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL miss_status got %h exp 0000", d); end
    peek(8'hA6, d);
    n_tests++; if (d !== 16'h00CD) begin n_fail++; $display("FAIL miss_clkdiv got %h exp 00cd", d); end
    n_tests++; if (cs_n !== 1'b0 || sclk !== 1'b0) begin n_fail++; $display("FAIL miss_pins got cs_n=%b sclk=%b exp 0 0", cs_n, sclk); end
    wr(8'hA4, 16'h0000);
    n_tests++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL ctrl_deselect got %b exp 1", cs_n); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    int e0;
    loop_mode = 1'b0; pat_byte = 8'h00;
    wr(8'hA6, 16'd9);
    wr(8'hA2, 16'h003C);
    wr(8'hA2, 16'h0011);
    repeat (25) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_tests++; if (sclk !== 1'b0 || mosi !== 1'b1) begin n_fail++; $display("FAIL midrst_pins got %b%b exp 01", sclk, mosi); end
    peek(8'hA0, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL midrst_status got %h exp 0000", d); end
    #1 reset = 1'b1;
    e0 = edges;
    repeat (40) @(posedge clk);
    #1;
    peek(8'hA0, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL midrst_after got %h exp 0000", d); end
    n_tests++; if (edges != e0) begin n_fail++; $display("FAIL midrst_no_restart got %0d exp %0d", edges, e0); end
    peek(8'hA6, d);
    n_tests++; if (d !== 16'h00FF) begin n_fail++; $display("FAIL midrst_clkdiv got %h exp 00ff", d); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_buffered();
    test_random();
    test_overrun();
    test_ctrl_miss();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
